lenet_layer_sequencer: RTL
==========================

# lenet_layer_sequencer

- Top-level controller for the LeNet accelerator. It runs the five layer engines (C1, C2, C3, F4, F5) one after another for a selected image.
- It snapshots the F5 output vector and finds the winning class with a sequential signed argmax.
- It reports completion and per-layer progress to the board-level outputs (seven-segment, RGB LED).
- It sits between the top-level `start`/`graph` controls and the layer engines' start/finish handshakes.

## Interface
- `OUTPUT_NODE`, 10: number of F5 output nodes (classes).
- `DATA_SIZE`, 8: width of each F5 output (signed two's complement).
- `TIMEOUT_CYCLES`, 1048576: per-layer watchdog limit. Used only with `LENET_SEQ_TIMEOUT_EN`.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request, level input. A run launches on a rising edge.
- `graph`  in  5  image index, latched at launch.
- `result`  in  DATA_SIZE*OUTPUT_NODE  F5 outputs. Node 0 is at the LSBs.
- `layer_done`  in  5  finish pulses from the engines: [0]=C1 … [4]=F5.
- `layer_start`  out  5  one-hot, single-cycle start pulse to the engines, same bit order as `layer_done`.
- `graph_sel`  out  5  latched image index.
- `busy`  out  1  a run is in progress.
- `done_flags`  out  5  sticky per-layer finish flags (c1…f5 finish).
- `lenet_finish`  out  1  single-cycle pulse at the end of a run.
- `class_idx`  out  4  argmax result.
- `class_valid`  out  1  sticky; `class_idx` is valid.
- `err`  out  1  sticky watchdog error.
- `led_rgb`  out  3  status: idle 3'b001, busy 3'b010, done 3'b100, err 3'b110.

## Operation
- Reset values: every output is 0 except `led_rgb`=3'b001. Internal `start_q`=0, state IDLE.
- Launch condition: `start`=1 and `start_q`=0, evaluated only in IDLE.
  - A `start` held high after a run does not relaunch.
  - The first cycle after reset with `start`=1 does launch.
- On launch: latch `graph` into `graph_sel`; clear `done_flags`, `class_valid` and `err`; set layer index k=0.
- FSM states: IDLE, LAUNCH, WAIT, ARGMAX, DONE.
  - IDLE → LAUNCH on the launch condition.
  - LAUNCH: `layer_start[k]`=1 for one cycle → WAIT.
  - WAIT: when `layer_done[k]`=1, set `done_flags[k]`.
    - If k<4: k++ and go to LAUNCH.
    - If k=4: snapshot `result` and go to ARGMAX.
  - ARGMAX: one node per cycle, node 0..OUTPUT_NODE-1, signed compare.
    - Replace the best value only on strictly greater, so ties resolve to the lowest index.
    - After the last node → DONE.
  - DONE: `lenet_finish`=1, `class_valid`=1 → IDLE.
- In WAIT, `layer_done` bits other than bit k are ignored. All of `layer_done` is ignored outside WAIT.
- Start edges while `busy` are ignored; `start_q` still tracks `start`.
- `rst` mid-run: the next cycle shows reset values and `layer_start` is 0. No partial flags or finish pulse are retained.
- `result` changing during ARGMAX has no effect, because the snapshot is used.

## Timing
- Launch edge sampled in cycle N:
  - Cycle N+1: `layer_start[0]`=1 and `busy`=1.
  - Cycle N+2: WAIT.
- `layer_done[k]` sampled in cycle M, k<4: `layer_start[k+1]` high in cycle M+1.
- `layer_done[4]` sampled in cycle M:
  - ARGMAX occupies M+1 … M+OUTPUT_NODE.
  - `lenet_finish` pulse and `class_valid` rise in cycle M+OUTPUT_NODE+1.
  - `busy` falls in cycle M+OUTPUT_NODE+2.
- Sequencer overhead per run: 5 launch cycles + OUTPUT_NODE + 2.
- Minimum gap before a new launch edge is accepted: the cycle after `busy` falls.
- All outputs are registered.

## Configuration
- `LENET_SEQ_TIMEOUT_EN` defined:
  - A 20-bit cycle counter clears on LAUNCH and counts in WAIT.
  - If it reaches TIMEOUT_CYCLES-1 without `layer_done[k]`: set `err`, drive `led_rgb`=3'b110, go to IDLE with `busy`=0.
  - No `lenet_finish` and no `class_valid` for that run.
  - `err` clears on the next launch or on `rst`.
- Not defined: no counter is built, `err` is tied 0, and WAIT waits indefinitely.

## Structure
- Shared package `lenet_pkg`:
  - OUTPUT_NODE and DATA_SIZE constants.
  - Layer index constants C1…F5 (0…4).
  - State enum `seq_state_t`.
  - LED status constants.
- One sub-module, `lenet_argmax_seq`:
  - Handshake: `load` (snapshot) followed by `OUTPUT_NODE` step cycles.
  - Outputs `idx` and `valid`.
  - The FSM sequences it.

## Test plan
- Reset, then `start` 0→1 with `graph`=4; engine model returns each done 20 cycles after its start. Expect:
  - Five ordered one-hot `layer_start` pulses.
  - `done_flags` going 00001 → 11111.
  - `graph_sel`=4.
  - One `lenet_finish`, at `layer_done[4]`+11.
- `result` nodes {3:+50, 7:+50, others −10}: `class_idx`=3. With all nodes −128: `class_idx`=0. Node 9 = +127, others 0: `class_idx`=9.
- Hold `start`=1 after finish: no second launch. Pulse `start` 0→1 during a run: ignored, with exactly five `layer_start` pulses.
- Assert `layer_done[3]` while waiting on C2: no advance and `done_flags`=00001. Then the correct `layer_done[1]` advances to C3.
- Assert `rst` one cycle while waiting on F4: next cycle all outputs are at reset values. A new `start` edge (`graph`=2) completes normally.
- With `LENET_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64, C3 never finishes: `err`=1, `led_rgb`=3'b110 and `busy`=0 after 64 WAIT cycles, with no `lenet_finish`. The next launch clears `err`.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared constants, layer indices, sequencer state encoding and LED codes
// for the LeNet accelerator control path.
package lenet_pkg;

  localparam int OUTPUT_NODE = 10;
  localparam int DATA_SIZE   = 8;
  localparam int NUM_LAYERS  = 5;

  localparam logic [2:0] LAYER_C1 = 3'd0;
  localparam logic [2:0] LAYER_C2 = 3'd1;
  localparam logic [2:0] LAYER_C3 = 3'd2;
  localparam logic [2:0] LAYER_F4 = 3'd3;
  localparam logic [2:0] LAYER_F5 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ARGMAX,
    S_DONE
  } seq_state_t;

  localparam logic [2:0] LED_IDLE = 3'b001;
  localparam logic [2:0] LED_BUSY = 3'b010;
  localparam logic [2:0] LED_DONE = 3'b100;
  localparam logic [2:0] LED_ERR  = 3'b110;

endpackage

// File: rtl/lenet_argmax_seq.sv
// Sequential signed argmax over a snapshot of the F5 output vector:
// one node per step cycle, ties resolve to the lowest index.
module lenet_argmax_seq
  import lenet_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              load,
  input  logic                              step,
  input  logic [DATA_SIZE*OUTPUT_NODE-1:0]  data,
  output logic [3:0]                        idx,
  output logic                              valid,
  output logic                              last
);

  logic [DATA_SIZE*OUTPUT_NODE-1:0] snap;
  logic [3:0]                       cnt;
  logic [DATA_SIZE-1:0]             best;
  logic [3:0]                       best_idx;
  logic [DATA_SIZE-1:0]             cur;
  logic                             take;
  logic [3:0]                       cand_idx;

  always_comb begin
    cur = '0;
    for (int i = 0; i < OUTPUT_NODE; i++) begin
      if (cnt == 4'(i)) cur = snap[i*DATA_SIZE +: DATA_SIZE];
    end
    // Node 0 seeds the running best; later nodes win only when strictly greater.
    take     = (cnt == 4'd0) || ($signed(cur) > $signed(best));
    cand_idx = take ? cnt : best_idx;
    last     = step && (cnt == 4'(OUTPUT_NODE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap     <= '0;
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
      idx      <= '0;
      valid    <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      snap  <= data;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (step) begin
      if (take) begin
        best     <= cur;
        best_idx <= cnt;
      end
      if (last) begin
        idx   <= cand_idx;
        valid <= 1'b1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/lenet_layer_sequencer.sv
// Runs C1..F5 in order, then argmaxes the F5 outputs and reports status.
// Optional per-layer watchdog enabled by defining LENET_SEQ_TIMEOUT_EN.
module lenet_layer_sequencer
  import lenet_pkg::*;
`ifdef LENET_SEQ_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 1048576
)
`endif
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [4:0]                        graph,
  input  logic [DATA_SIZE*OUTPUT_NODE-1:0]  result,
  input  logic [4:0]                        layer_done,
  output logic [4:0]                        layer_start,
  output logic [4:0]                        graph_sel,
  output logic                              busy,
  output logic [4:0]                        done_flags,
  output logic                              lenet_finish,
  output logic [3:0]                        class_idx,
  output logic                              class_valid,
  output logic                              err,
  output logic [2:0]                        led_rgb
);

  seq_state_t state, state_n;
  logic [2:0] k, k_n;
  logic       start_q;
  logic [4:0] layer_start_n, graph_sel_n, done_flags_n;
  logic       busy_n, lenet_finish_n;
  logic [2:0] led_n;
  logic       arg_clear, arg_load, arg_step, arg_last;

`ifdef LENET_SEQ_TIMEOUT_EN
  localparam logic [19:0] TIMER_MAX = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] timer, timer_n;
  logic        err_q, err_n;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  lenet_argmax_seq u_argmax (
    .clk   (clk),
    .rst   (rst),
    .clear (arg_clear),
    .load  (arg_load),
    .step  (arg_step),
    .data  (result),
    .idx   (class_idx),
    .valid (class_valid),
    .last  (arg_last)
  );

  // Outputs are computed alongside the next state so that every port is a flop.
  always_comb begin
    state_n        = state;
    k_n            = k;
    layer_start_n  = '0;
    graph_sel_n    = graph_sel;
    busy_n         = busy;
    done_flags_n   = done_flags;
    lenet_finish_n = 1'b0;
    led_n          = led_rgb;
    arg_clear      = 1'b0;
    arg_load       = 1'b0;
    arg_step       = 1'b0;
`ifdef LENET_SEQ_TIMEOUT_EN
    timer_n        = timer;
    err_n          = err_q;
`endif
    case (state)
      S_IDLE: begin
        if (start && !start_q) begin
          state_n       = S_LAUNCH;
          k_n           = LAYER_C1;
          layer_start_n = 5'b00001;
          graph_sel_n   = graph;
          busy_n        = 1'b1;
          done_flags_n  = '0;
          arg_clear     = 1'b1;
          led_n         = LED_BUSY;
`ifdef LENET_SEQ_TIMEOUT_EN
          err_n         = 1'b0;
`endif
        end
      end
      S_LAUNCH: begin
        state_n = S_WAIT;
`ifdef LENET_SEQ_TIMEOUT_EN
        timer_n = '0;
`endif
      end
      S_WAIT: begin
        if (layer_done[k]) begin
          done_flags_n[k] = 1'b1;
          if (k == LAYER_F5) begin
            state_n  = S_ARGMAX;
            arg_load = 1'b1;
          end else begin
            k_n           = k + 3'd1;
            state_n       = S_LAUNCH;
            layer_start_n = 5'b00001 << (k + 3'd1);
          end
        end
`ifdef LENET_SEQ_TIMEOUT_EN
        else if (timer == TIMER_MAX) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          led_n   = LED_ERR;
        end else begin
          timer_n = timer + 20'd1;
        end
`endif
      end
      S_ARGMAX: begin
        arg_step = 1'b1;
        if (arg_last) begin
          state_n        = S_DONE;
          lenet_finish_n = 1'b1;
          led_n          = LED_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      k            <= '0;
      start_q      <= 1'b0;
      layer_start  <= '0;
      graph_sel    <= '0;
      busy         <= 1'b0;
      done_flags   <= '0;
      lenet_finish <= 1'b0;
      led_rgb      <= LED_IDLE;
`ifdef LENET_SEQ_TIMEOUT_EN
      timer        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      k            <= k_n;
      start_q      <= start;
      layer_start  <= layer_start_n;
      graph_sel    <= graph_sel_n;
      busy         <= busy_n;
      done_flags   <= done_flags_n;
      lenet_finish <= lenet_finish_n;
      led_rgb      <= led_n;
`ifdef LENET_SEQ_TIMEOUT_EN
      timer        <= timer_n;
      err_q        <= err_n;
`endif
    end
  end

endmodule
